// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: ALU operand forward selects and selection helper.
package pipeline_hazard_unit_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // Operand-mux encoding decoded by the datapath.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Youngest producer wins; an unread operand always takes the register file.
  function automatic fwd_sel_t fwd_pick(input logic use_r, input logic hit_ex, input logic hit_mem);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_r && hit_ex) begin
      sel = FWD_MEM;
    end else if (use_r && hit_mem) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Controller-side view of the hazard unit: ID-stage instruction info in, hold/flush/forward controls out.
interface pipeline_hazard_unit_if
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic              run;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_RegWr;
  logic              id_MemtoReg;
  logic [REG_AW-1:0] id_dst;
  logic              ex_redirect;

  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output run, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_RegWr, id_MemtoReg, id_dst, ex_redirect,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  run, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_RegWr, id_MemtoReg, id_dst, ex_redirect,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts enabled increments and sticks at all-ones.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: shadow scoreboard of EX/MEM producers drives
// load-use stalls, redirect flushes, registered operand forwarding and perf counters.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_unit_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] dst;
  } ex_entry_t;

  // The MEM entry only feeds WB forwarding, so the load flag is not carried past EX.
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dst;
  } mem_entry_t;

  ex_entry_t  ex_q;
  ex_entry_t  ex_d;
  mem_entry_t mem_q;
  fwd_sel_t   fwd_a_q;
  fwd_sel_t   fwd_b_q;
  fwd_sel_t   fwd_a_d;
  fwd_sel_t   fwd_b_d;
  logic       active;
  logic       load_use;
  logic       squash;

  function automatic logic prod_hit(input logic v, input logic wr,
                                    input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] r);
    return v & wr & (dst != '0) & (dst == r);
  endfunction

  // Hazard detection and next EX entry / forward selects for the ID instruction.
  always_comb begin
    active   = bus.run & rst_n;
    load_use = bus.id_valid & ex_q.valid & ex_q.load & (ex_q.dst != '0) &
               ((bus.id_use_rs & (bus.id_rs == ex_q.dst)) |
                (bus.id_use_rt & (bus.id_rt == ex_q.dst)));
    squash   = bus.ex_redirect | load_use;

    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!squash && bus.id_valid) begin
      ex_d.valid = 1'b1;
      ex_d.wr    = bus.id_RegWr;
      ex_d.load  = bus.id_MemtoReg;
      ex_d.dst   = bus.id_dst;
      fwd_a_d    = fwd_pick(bus.id_use_rs,
                            prod_hit(ex_q.valid, ex_q.wr, ex_q.dst, bus.id_rs),
                            prod_hit(mem_q.valid, mem_q.wr, mem_q.dst, bus.id_rs));
      fwd_b_d    = fwd_pick(bus.id_use_rt,
                            prod_hit(ex_q.valid, ex_q.wr, ex_q.dst, bus.id_rt),
                            prod_hit(mem_q.valid, mem_q.wr, mem_q.dst, bus.id_rt));
    end
  end

  // Pipeline control; a redirect squashes the stalled instruction, so it wins over load-use.
  always_comb begin
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (active) begin
      if (bus.ex_redirect) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
      end else if (load_use) begin
        bus.pc_hold     = 1'b1;
        bus.ifid_hold   = 1'b1;
        bus.idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (bus.run) begin
      ex_q    <= ex_d;
      mem_q   <= '{valid: ex_q.valid, wr: ex_q.wr, dst: ex_q.dst};
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.run),
    .inc   (load_use & ~bus.ex_redirect),
    .count (bus.stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.run),
    .inc   (bus.ex_redirect),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: per-cycle vector table plus reset, freeze and saturation sequences.
module tb_pipeline_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipeline_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic       ld;
    logic [4:0] dst;
    logic       redir;
    logic [3:0] haz;   // {pc_hold, ifid_hold, ifid_flush, idex_bubble}
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] sc;
    logic [1:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int v, input int rs, input int rt, input int urs, input int urt,
                              input int wr, input int ld, input int dst, input int redir,
                              input int haz, input int fa, input int fb, input int sc, input int fc);
    vec_t r;
    r.v = 1'(v);     r.rs = 5'(rs);   r.rt = 5'(rt);   r.urs = 1'(urs); r.urt = 1'(urt);
    r.wr = 1'(wr);   r.ld = 1'(ld);   r.dst = 5'(dst); r.redir = 1'(redir);
    r.haz = 4'(haz); r.fa = 2'(fa);   r.fb = 2'(fb);   r.sc = 2'(sc);   r.fc = 2'(fc);
    return r;
  endfunction

  task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int wr, input int ld, input int dst, input int redir);
    bus.id_valid    = 1'(v);
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_use_rs   = 1'(urs);
    bus.id_use_rt   = 1'(urt);
    bus.id_RegWr    = 1'(wr);
    bus.id_MemtoReg = 1'(ld);
    bus.id_dst      = 5'(dst);
    bus.ex_redirect = 1'(redir);
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int haz, input int fa, input int fb,
                         input int sc, input int fc);
    chk({tag, " haz"}, 32'({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble}),
        32'(haz));
    chk({tag, " fwd"}, 32'({bus.fwd_a, bus.fwd_b}), 32'({2'(fa), 2'(fb)}));
    chk({tag, " cnt"}, 32'({bus.stall_cnt, bus.flush_cnt}), 32'({2'(sc), 2'(fc)}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three-cycle load followed by a dependent use; checks the single stall cycle.
  task automatic load_use_pair(input string tag, input int dst, input int sc_before, input int fc);
    drive(1, 1, 0, 1, 0, 1, 1, dst, 0);
    tick();
    drive(1, dst, 0, 1, 0, 1, 0, 20, 0);
    #2;
    chk({tag, " stall haz"}, 32'({bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_bubble}),
        32'h0000_000d);
    chk({tag, " stall cnt"}, 32'({bus.stall_cnt, bus.flush_cnt}), 32'({2'(sc_before), 2'(fc)}));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    //       v rs rt us ut wr ld dst rd   haz    fa fb sc fc
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 1, 8, 0, 4'b0000, 0, 0, 0, 0)); // lw $8
    vecs.push_back(mk(1, 8, 8, 1, 1, 1, 0, 9, 0, 4'b1101, 0, 0, 0, 0)); // add $9,$8,$8 stalls
    vecs.push_back(mk(1, 8, 8, 1, 1, 1, 0, 9, 0, 4'b0000, 0, 0, 1, 0)); // add re-issued
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2, 2, 1, 0)); // add in EX from WB
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 4'b0000, 0, 0, 1, 0)); // add $3
    vecs.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 4'b0000, 0, 0, 1, 0)); // sub $4,$3,$5
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 4'b0000, 1, 0, 1, 0)); // sub in EX: a from MEM
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0)); // nop gap
    vecs.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 4'b0000, 0, 0, 1, 0)); // sub $4,$3,$5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2, 0, 1, 0)); // sub in EX: a from WB
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 6, 0, 4'b0000, 0, 0, 1, 0)); // add $6
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 6, 0, 4'b0000, 0, 0, 1, 0)); // add $6 again
    vecs.push_back(mk(1, 6, 6, 1, 1, 1, 0, 7, 0, 4'b0000, 0, 0, 1, 0)); // or $7,$6,$6
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 0)); // nearest producer wins
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 1, 0)); // lw $0
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 9, 0, 4'b0000, 0, 0, 1, 0)); // use $0: no stall
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 1, 0)); // add $0
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 9, 0, 4'b0000, 0, 0, 1, 0)); // use $0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0)); // $0 never forwarded
    vecs.push_back(mk(1, 1, 2, 1, 1, 1, 0, 10, 0, 4'b0000, 0, 0, 1, 0)); // add $10
    vecs.push_back(mk(1, 10, 10, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0)); // reads rt only
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0)); // fa RF, fb MEM
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 1, 11, 0, 4'b0000, 0, 0, 1, 0)); // lw $11
    vecs.push_back(mk(1, 11, 11, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0, 1, 0)); // no real read
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 1, 12, 0, 4'b0000, 0, 0, 1, 0)); // lw $12
    vecs.push_back(mk(1, 12, 0, 1, 0, 1, 0, 13, 1, 4'b0011, 0, 0, 1, 0)); // load-use + redirect
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 1)); // flushed slot
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 14, 1, 4'b0011, 0, 0, 1, 1)); // plain redirect
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 2));

    // Reset held from time zero with a redirect pending: everything reads zero before any clock.
    bus.run = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
            vecs[i].wr, vecs[i].ld, vecs[i].dst, vecs[i].redir);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i].haz, vecs[i].fa, vecs[i].fb, vecs[i].sc, vecs[i].fc);
      tick();
    end

    // Async reset in the middle of a stall clears state at once with no leftover hold.
    drive(1, 1, 2, 1, 1, 1, 0, 13, 0);
    tick();
    drive(1, 13, 0, 1, 0, 1, 1, 14, 0);
    #2;
    chk_all("mid lw", 0, 0, 0, 1, 2);
    tick();
    drive(1, 14, 14, 1, 1, 1, 0, 15, 0);
    #2;
    chk_all("pre-reset stall", 4'b1101, 1, 0, 1, 2);
    bus.ex_redirect = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 0);
    bus.ex_redirect = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_all("post-release", 0, 0, 0, 0, 0);
    tick();
    #2;
    chk_all("no residual", 0, 0, 0, 0, 0);

    // Freeze during a stall, then resume the identical stall.
    drive(1, 1, 0, 1, 0, 1, 1, 8, 0);
    tick();
    drive(1, 8, 8, 1, 1, 1, 0, 9, 0);
    #2;
    chk_all("freeze pre", 4'b1101, 0, 0, 0, 0);
    bus.run = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.ex_redirect = (c == 2);
      #1;
      chk_all($sformatf("frozen%0d", c), 0, 0, 0, 0, 0);
      tick();
    end
    bus.ex_redirect = 1'b0;
    bus.run = 1'b1;
    #1;
    chk_all("resume stall", 4'b1101, 0, 0, 0, 0);
    tick();
    #1;
    chk_all("resume bubble", 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_all("resume fwd", 0, 2, 2, 1, 0);
    tick();

    // Counter saturation at all-ones with a 2-bit counter.
    load_use_pair("sat1", 16, 1, 0);
    load_use_pair("sat2", 17, 2, 0);
    load_use_pair("sat3", 18, 3, 0);
    #2;
    chk("stall sat", 32'(bus.stall_cnt), 32'd3);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("flush sat", 0, 0, 0, 3, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
